// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 definitions used by the encryption and
// decryption cores.
//   - widths and round count
//   - S-box / inverse S-box tables (packed nibble tables)
//   - bit permutation and its inverse
//   - forward and inverse key-schedule steps
//   - FSM state and key-schedule operation enums
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int BLOCK_W    = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

  // Nibble x of the table holds S[x]; entry 0 sits in the low nibble.
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEXP   = 3'd1,
    ST_WHITEN = 3'd2,
    ST_ROUNDS = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    KOP_HOLD        = 3'd0,
    KOP_LOAD        = 3'd1,
    KOP_FWD         = 3'd2,
    KOP_INV         = 3'd3,
    KOP_LOAD_CACHED = 3'd4
  } key_op_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
    return r;
  endfunction

  // Destination of bit i under the PRESENT permutation.
  function automatic int perm_pos(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < BLOCK_W; i++) r[perm_pos(i)] = s[i];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < BLOCK_W; i++) r[i] = s[perm_pos(i)];
    return r;
  endfunction

  // Forward step: rotate left 61, S-box top nibble, xor counter into [19:15].
  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                               input logic [CNT_W-1:0] i);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  // Exact inverse of key_fwd for the same counter value.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                               input logic [CNT_W-1:0] i);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ i;
    t[79:76]   = inv_sbox4(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present_dec_if.sv
// present_dec_if: request/response bundle of the PRESENT-80 decryption core.
//   start_signal (m->s) request, key (m->s) 80-bit key, block_i (m->s) ciphertext
//   block_o (s->m) plaintext, end_signal (s->m) result valid, busy (s->m)
//   dbg_state (s->m) current FSM state, for checkers and debug
//
// Handshake: start_signal is sampled together with key/block_i only while
// the core is not busy (IDLE or DONE); a request seen while busy is dropped,
// not queued. end_signal is a level: block_o is valid for as long as
// end_signal is high, and both hold until the next accepted start or reset.
interface present_dec_if;
  import present_pkg::*;

  logic               start_signal;
  logic [KEY_W-1:0]   key;
  logic [BLOCK_W-1:0] block_i;
  logic [BLOCK_W-1:0] block_o;
  logic               end_signal;
  logic               busy;
  state_t             dbg_state;

  modport master (
    output start_signal, key, block_i,
    input  block_o, end_signal, busy, dbg_state
  );

  modport slave (
    input  start_signal, key, block_i,
    output block_o, end_signal, busy, dbg_state
  );

endinterface

// File: rtl/present_inv_key_schedule.sv
// present_inv_key_schedule: key register for the decryption core.
//   clk, rst       clock and synchronous active-high reset
//   op             operation for this cycle (hold/load/forward/inverse/load cached)
//   cnt            round counter applied by the forward/inverse step
//   key_in         external key, loaded on KOP_LOAD and compared for cache hits
//   cache_hit      key_in matches the retained key and the retained K32 is valid
//   round_key      current round key k[79:16]
//   inv_round_key  round key after this cycle's inverse step
// With CACHE_KEY=1 the original key and the K32 reached at the end of forward
// expansion are retained so a repeated key can jump straight to K32.
module present_inv_key_schedule
  import present_pkg::*;
#(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  key_op_t            op,
  input  logic [CNT_W-1:0]   cnt,
  input  logic [KEY_W-1:0]   key_in,
  output logic               cache_hit,
  output logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] inv_round_key
);

  logic [KEY_W-1:0] k_q;
  logic [KEY_W-1:0] k_fwd;
  logic [KEY_W-1:0] k_inv;
  logic [KEY_W-1:0] cached_k32;
  logic             last_fwd;

  assign k_fwd         = key_fwd(k_q, cnt);
  assign k_inv         = key_inv(k_q, cnt);
  assign round_key     = k_q[79:16];
  assign inv_round_key = k_inv[79:16];

  // The forward step with the last counter value produces K32.
  assign last_fwd = (op == KOP_FWD) && (cnt == LAST_RND);

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else begin
      case (op)
        KOP_LOAD:        k_q <= key_in;
        KOP_FWD:         k_q <= k_fwd;
        KOP_INV:         k_q <= k_inv;
        KOP_LOAD_CACHED: k_q <= cached_k32;
        default:         k_q <= k_q;
      endcase
    end
  end

  generate
    if (CACHE_KEY) begin : g_cache
      logic [KEY_W-1:0] orig_key_q;
      logic [KEY_W-1:0] cache_key_q;
      logic [KEY_W-1:0] cache_k32_q;
      logic             cache_valid_q;

      always_ff @(posedge clk) begin
        if (rst) cache_valid_q <= 1'b0;
        else if (last_fwd) cache_valid_q <= 1'b1;
      end

      // The key register is consumed by expansion, so the original key is
      // kept aside until K32 is known and both can be stored together.
      always_ff @(posedge clk) begin
        if (op == KOP_LOAD) orig_key_q <= key_in;
        if (last_fwd) begin
          cache_key_q <= orig_key_q;
          cache_k32_q <= k_fwd;
        end
      end

      assign cache_hit  = cache_valid_q && (key_in == cache_key_q);
      assign cached_k32 = cache_k32_q;
    end else begin : g_no_cache
      assign cache_hit  = 1'b0;
      assign cached_k32 = '0;
    end
  endgenerate

endmodule

// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 decryption core, one round per cycle.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, dominates everything
//   bus   present_dec_if.slave: start_signal/key/block_i in,
//         block_o/end_signal/busy/dbg_state out
// Sequence: KEXP walks the key schedule forward to K32 (skipped on a cache
// hit), WHITEN xors K32 into the state, ROUNDS undoes rounds 31..1 while
// stepping the key schedule backwards, DONE holds the plaintext.
module present_dec
  import present_pkg::*;
#(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  present_dec_if.slave bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] st_q, st_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               end_q, end_d;

  key_op_t            kop;
  logic               cache_hit;
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] inv_round_key;
  logic [BLOCK_W-1:0] round_out;

  present_inv_key_schedule #(
    .CACHE_KEY (CACHE_KEY)
  ) u_key (
    .clk           (clk),
    .rst           (rst),
    .op            (kop),
    .cnt           (cnt_q),
    .key_in        (bus.key),
    .cache_hit     (cache_hit),
    .round_key     (round_key),
    .inv_round_key (inv_round_key)
  );

  // One inverse round; the key xored in is the one produced this cycle.
  assign round_out = inv_sbox_layer(inv_perm(st_q)) ^ inv_round_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      out_q   <= out_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    out_d   = out_q;
    end_d   = end_q;
    kop     = KOP_HOLD;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_signal) begin
          st_d  = bus.block_i;
          end_d = 1'b0;
          cnt_d = CNT_W'(1);
          if (cache_hit) begin
            kop     = KOP_LOAD_CACHED;
            state_d = ST_WHITEN;
          end else begin
            kop     = KOP_LOAD;
            state_d = ST_KEXP;
          end
        end
      end

      ST_KEXP: begin
        kop   = KOP_FWD;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_RND) state_d = ST_WHITEN;
      end

      ST_WHITEN: begin
        st_d    = st_q ^ round_key;
        cnt_d   = LAST_RND;
        state_d = ST_ROUNDS;
      end

      ST_ROUNDS: begin
        kop   = KOP_INV;
        st_d  = round_out;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d   = round_out;
          end_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.block_o    = out_q;
  assign bus.end_signal = end_q;
  assign bus.busy       = (state_q == ST_KEXP) || (state_q == ST_WHITEN) ||
                          (state_q == ST_ROUNDS);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_present_dec.sv
// tb_present_dec: drives a caching (CACHE_KEY=1) and a non-caching
// (CACHE_KEY=0) present_dec from the same stimulus and checks plaintext and
// completion cycle of each against a behavioural PRESENT-80 model.
module tb_present_dec;
  import present_pkg::*;

  localparam int LAT_FULL = 63;
  localparam int LAT_HIT  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic         start = 1'b0;
  logic [79:0]  key = '0;
  logic [63:0]  block_i = '0;

  present_dec_if bus1();
  present_dec_if bus0();

  assign bus1.start_signal = start;
  assign bus1.key          = key;
  assign bus1.block_i      = block_i;
  assign bus0.start_signal = start;
  assign bus0.key          = key;
  assign bus0.block_i      = block_i;

  present_dec #(.CACHE_KEY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  present_dec #(.CACHE_KEY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // ---------------- reference model ----------------
  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Round key K_r (r = 1..32) of the forward schedule.
  function automatic logic [63:0] m_round_key(input logic [79:0] k0, input int r);
    logic [79:0] k;
    logic [4:0]  rc;
    k = k0;
    for (int i = 1; i < r; i++) begin
      rc       = i[4:0];
      k        = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
    end
    return k[79:16];
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, t;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ m_round_key(k, r);
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
      for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : (b * 16) % 63] = t[b];
    end
    return s ^ m_round_key(k, 32);
  endfunction

  // Which key the caching core would have retained.
  logic        mdl_valid = 1'b0;
  logic [79:0] mdl_key   = '0;

  function automatic int cache_lat(input logic [79:0] k);
    return (mdl_valid && mdl_key == k) ? LAT_HIT : LAT_FULL;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int          cyc_q0[$];
  int          cyc_q1[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_val(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flush_expect();
    exp_q0.delete(); exp_q1.delete(); cyc_q0.delete(); cyc_q1.delete();
  endtask

  // ---------------- monitors ----------------
  logic prev_end0 = 1'b0;
  logic prev_end1 = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus0.end_signal && !prev_end0) begin
      if (exp_q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_spurious_end: end_signal rose at cycle %0d, nothing pending", cyc);
      end else begin
        check_val("dut0_block_o", 80'(bus0.block_o), 80'(exp_q0.pop_front()));
        check_val("dut0_end_cycle", 80'(cyc), 80'(cyc_q0.pop_front()));
      end
    end
    prev_end0 <= bus0.end_signal;
  end

  always @(negedge clk) begin
    if (!rst && bus1.end_signal && !prev_end1) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_spurious_end: end_signal rose at cycle %0d, nothing pending", cyc);
      end else begin
        check_val("dut1_block_o", 80'(bus1.block_o), 80'(exp_q1.pop_front()));
        check_val("dut1_end_cycle", 80'(cyc), 80'(cyc_q1.pop_front()));
      end
    end
    prev_end1 <= bus1.end_signal;
  end

  // ---------------- driver tasks ----------------
  // Start is sampled on the edge after this negedge, i.e. edge cyc+1.
  task automatic issue(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    @(negedge clk);
    key = k; block_i = ct; start = 1'b1;
    exp_q0.push_back(pt); cyc_q0.push_back(cyc + 1 + LAT_FULL);
    exp_q1.push_back(pt); cyc_q1.push_back(cyc + 1 + cache_lat(k));
    mdl_valid = 1'b1; mdl_key = k;
    @(negedge clk);
    start = 1'b0;
    check_val("dut0_busy_after_start", 80'(bus0.busy), 80'(1));
    check_val("dut1_busy_after_start", 80'(bus1.busy), 80'(1));
  endtask

  // Start held across completion: each core restarts the same request the
  // edge after end_signal rises. k must miss the cache so both cores finish
  // the first pass together.
  task automatic issue_held(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    int e0, e1;
    @(negedge clk);
    key = k; block_i = ct; start = 1'b1;
    e0 = cyc + 1 + LAT_FULL;
    e1 = cyc + 1 + cache_lat(k);
    mdl_valid = 1'b1; mdl_key = k;
    exp_q0.push_back(pt); cyc_q0.push_back(e0);
    exp_q1.push_back(pt); cyc_q1.push_back(e1);
    exp_q0.push_back(pt); cyc_q0.push_back(e0 + 1 + LAT_FULL);
    exp_q1.push_back(pt); cyc_q1.push_back(e1 + 1 + cache_lat(k));
    while (cyc < e0 + 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d/%0d results pending after %0d cycles",
               exp_q0.size(), exp_q1.size(), budget);
      flush_expect();
    end
    @(negedge clk);
    check_val("dut0_idle_busy", 80'(bus0.busy), 80'(0));
    check_val("dut1_idle_busy", 80'(bus1.busy), 80'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dut0_block_o"}, 80'(bus0.block_o), 80'(0));
    check_val({tag, "_dut0_end"},     80'(bus0.end_signal), 80'(0));
    check_val({tag, "_dut0_busy"},    80'(bus0.busy), 80'(0));
    check_val({tag, "_dut1_block_o"}, 80'(bus1.block_o), 80'(0));
    check_val({tag, "_dut1_end"},     80'(bus1.end_signal), 80'(0));
    check_val({tag, "_dut1_busy"},    80'(bus1.busy), 80'(0));
    check_val({tag, "_dut1_state"},   80'(bus1.dbg_state), 80'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] P_ONES = {64{1'b1}};

  initial begin
    logic [79:0] k_rnd, k_held;
    logic [79:0] pool [3];
    logic [63:0] pt;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Known-answer vectors; the second key-0 request hits the cache.
    issue('0, 64'h5579C1387B228445, 64'h0);
    wait_drain(200);
    issue('0, 64'hA112FFC72F68417B, P_ONES);
    wait_drain(200);
    issue(K_ONES, 64'hE72C46C0F5945049, 64'h0);
    wait_drain(200);
    issue(K_ONES, 64'h3333DCD3213210D2, P_ONES);
    wait_drain(200);

    // Requests while busy must be ignored.
    k_rnd = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
    pt    = {$urandom, $urandom};
    issue(k_rnd, m_encrypt(pt, k_rnd), pt);
    repeat (4) @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      start = 1'b1;
      key = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
      block_i = {$urandom, $urandom};
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    check_val("dut0_busy_ignored", 80'(bus0.busy), 80'(1));
    check_val("dut1_busy_ignored", 80'(bus1.busy), 80'(1));
    wait_drain(200);

    // Start held high through DONE: back-to-back restart.
    k_held = 80'h0123456789ABCDEF0123;
    pt     = {$urandom, $urandom};
    issue_held(k_held, m_encrypt(pt, k_held), pt);
    wait_drain(200);

    // Reset in the middle of ROUNDS discards the result and the cache.
    issue('0, 64'h5579C1387B228445, 64'h0);
    while (cyc < cyc_q0[0] - 24) @(negedge clk);
    check_val("dut0_state_before_rst", 80'(bus0.dbg_state), 80'(ST_ROUNDS));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    flush_expect();
    mdl_valid = 1'b0;
    issue('0, 64'h5579C1387B228445, 64'h0);
    wait_drain(200);

    // Random requests over a small key pool so cache hits and misses mix.
    pool[0] = '0;
    pool[1] = K_ONES;
    pool[2] = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
    for (int n = 0; n < 12; n++) begin
      k_rnd = pool[$urandom_range(0, 2)];
      pt    = {$urandom, $urandom};
      issue(k_rnd, m_encrypt(pt, k_rnd), pt);
      wait_drain(200);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/present_dec.md
Name: present_dec

Overview:
- Iterative PRESENT-80 block decryption core; the inverse-direction counterpart of present_enc.
- Decrypts one 64-bit block per start, with an 80-bit key, one round per cycle.
- Computes the final round key K32 internally, then walks the key schedule backwards on the fly.
- Used by future CBC/ECB decrypt wrappers next to the existing CTR path.

Parameters:
- CACHE_KEY, 1: when 1, the core retains the last key and its K32 so a repeated key skips forward key expansion; when 0, no cache logic.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_signal  input  1  request; sampled only in IDLE or DONE.
- key  input  80  cipher key; sampled with start_signal.
- block_i  input  64  ciphertext; sampled with start_signal.
- block_o  output  64  plaintext; registered; valid while end_signal=1.
- end_signal  output  1  high in DONE.
- busy  output  1  high in KEXP, WHITEN, ROUNDS.

Behaviour:
- Reset, on a clk edge with rst=1:
  - FSM goes to IDLE; block_o=0, end_signal=0, busy=0.
  - Round counter=0; cache valid bit cleared.
  - rst dominates start_signal, including mid-operation; a partial result is discarded.
- Key schedule, with key register k[79:0] and round key k[79:16]:
  - Forward update with counter i: rotate left 61, S-box on k[79:76], k[19:15] ^= i[4:0].
  - Inverse update with counter i: k[19:15] ^= i[4:0], inverse S-box on k[79:76], rotate right 61.
- FSM states: IDLE, KEXP, WHITEN, ROUNDS, DONE.
- IDLE or DONE, start_signal=1:
  - Latch key into the key register and block_i into the state register.
  - Clear end_signal; counter=1.
  - Go to KEXP.
  - Exception: if CACHE_KEY=1, cache valid, and key equals the cached key, load the cached K32 key register and go to WHITEN.
- KEXP:
  - Each cycle applies the forward update with the counter, then counter++.
  - On the cycle that applies i=31, go to WHITEN; this takes 31 cycles.
  - On exit, if CACHE_KEY=1, store the key and the resulting K32 register and set the cache valid bit.
- WHITEN, 1 cycle:
  - state ^= k[79:16].
  - counter=31; go to ROUNDS.
- ROUNDS, one cycle per round for counter i=31 down to 1:
  - k' = inverse_update(k, i).
  - state = invS(invP(state)) ^ k'[79:16], where invP is the inverse bit permutation and invS is the inverse S-box applied to all 16 nibbles.
  - k = k'; counter--.
  - On the cycle processing i=1: load block_o with the new state, set end_signal=1, go to DONE.
- DONE:
  - block_o and end_signal hold until the next accepted start or rst.
  - A start in DONE is accepted in the same cycle as in IDLE.
- start_signal while busy is ignored; key and block_i changes while busy have no effect.
- Latency, from the edge sampling start_signal to end_signal high:
  - 63 cycles without a cache hit: 31 KEXP + 1 WHITEN + 31 ROUNDS.
  - 32 cycles on a cache hit.
- Back-to-back: a start held high in DONE restarts immediately; end_signal drops on the next edge.

Decomposition:
- Shared package present_pkg (reused by present_enc):
  - S-box and inverse S-box constants.
  - Permutation and inverse permutation functions.
  - Round count constant NUM_ROUNDS=31.
  - Key and block width localparams.
  - FSM state enum typedef.
- Sub-module present_inv_key_schedule:
  - Holds the key register, forward/inverse update, and the key cache.
  - Driven by an op select (load, forward, inverse, load_cached) and the counter from the FSM.

Test Plan:
- key=0, block_i=5579C1387B228445 -> block_o=0000000000000000, end_signal rises exactly 63 cycles after start.
- key=FFFF_FFFFFFFFFFFFFFFF, block_i=E72C46C0F5945049 -> block_o=0000000000000000.
- key=0, block_i=A112FFC72F68417B -> 0xFFFFFFFFFFFFFFFF; then key all-ones, block_i=3333DCD3213210D2 -> 0xFFFFFFFFFFFFFFFF.
- CACHE_KEY=1: decrypt the test-1 vector, then start again with the same key and block_i=A112FFC72F68417B -> block_o=FFFFFFFFFFFFFFFF after 32 cycles. With CACHE_KEY=0 the same sequence takes 63 cycles.
- rst pulsed in ROUNDS (cycle 40) -> next cycle block_o=0, end_signal=0, busy=0. A subsequent repeat-key start takes 63 cycles (cache invalidated).
- start toggled and block_i changed while busy -> ignored, result equals the first request's plaintext. start held high through DONE -> a second decryption begins, end_signal low for exactly 63 cycles.
